// File: rtl/pe_pkg.sv
// Shared types for the reconfigurable systolic PE: operating modes, control states
// and the bit positions inside the flow-direction field.
package pe_pkg;

  typedef enum logic [1:0] {
    PE_WS   = 2'b00,
    PE_OS   = 2'b01,
    PE_PASS = 2'b10,
    PE_RSVD = 2'b11
  } pe_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_DRAIN = 2'b10
  } pe_state_e;

  // cfg_dir bit 0 selects horizontal flow (1: E->W), bit 1 vertical flow (1: S->N)
  localparam int DIR_H = 0;
  localparam int DIR_V = 1;

endpackage

// File: rtl/pe_mac_core.sv
// Combinational multiply, extend and accumulate for the PE datapath.
// Build option: define PE_SAT_EN to clamp the sum to the ACC_W range instead of wrapping.
module pe_mac_core #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [ACC_W-1:0]  addend,
  output logic [ACC_W-1:0]  sum
);

  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  prod_ext;

  function automatic logic [ACC_W-1:0] add_acc(input logic [ACC_W-1:0] x,
                                                input logic [ACC_W-1:0] y);
`ifdef PE_SAT_EN
    logic [ACC_W:0]   s;
    logic [ACC_W-1:0] r;
    s = {1'b0, x} + {1'b0, y};
    r = s[ACC_W-1:0];
    if (SIGNED) begin
      // overflow only when both operands share a sign the result lost
      if ((x[ACC_W-1] == y[ACC_W-1]) && (r[ACC_W-1] != x[ACC_W-1]))
        r = x[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else if (s[ACC_W]) begin
      r = '1;
    end
    return r;
`else
    return x + y;
`endif
  endfunction

  generate
    if (SIGNED) begin : g_signed_mul
      logic signed [PROD_W-1:0] a_s;
      logic signed [PROD_W-1:0] b_s;
      logic signed [PROD_W-1:0] prod_s;
      assign a_s    = {{DATA_W{a[DATA_W-1]}}, a};
      assign b_s    = {{DATA_W{b[DATA_W-1]}}, b};
      assign prod_s = a_s * b_s;
      assign prod   = prod_s;
    end else begin : g_unsigned_mul
      assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
    end

    if (ACC_W > PROD_W) begin : g_ext
      assign prod_ext = {{(ACC_W-PROD_W){SIGNED ? prod[PROD_W-1] : 1'b0}}, prod};
    end else begin : g_noext
      assign prod_ext = prod;
    end
  endgenerate

  assign sum = add_acc(addend, prod_ext);

endmodule

// File: rtl/reconfig_pe.sv
// Mode-switchable systolic PE (WS / OS / PASS) with direction routing and accumulator drain.
// Build option: define PE_SAT_EN for saturating accumulate and WS psum (see pe_mac_core).
module reconfig_pe
  import pe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter bit SIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  input  logic [1:0]        cfg_mode,
  input  logic [1:0]        cfg_dir,
  input  logic              cfg_start,
  input  logic              cfg_stop,
  input  logic              stat_load,
  input  logic [DATA_W-1:0] stat_data,
  input  logic [DATA_W-1:0] h_in_w,
  input  logic              h_vld_w,
  input  logic [DATA_W-1:0] h_in_e,
  input  logic              h_vld_e,
  input  logic [ACC_W-1:0]  v_in_n,
  input  logic              v_vld_n,
  input  logic [ACC_W-1:0]  v_in_s,
  input  logic              v_vld_s,
  output logic [DATA_W-1:0] h_out_w,
  output logic              h_ovld_w,
  output logic [DATA_W-1:0] h_out_e,
  output logic              h_ovld_e,
  output logic [ACC_W-1:0]  v_out_n,
  output logic              v_ovld_n,
  output logic [ACC_W-1:0]  v_out_s,
  output logic              v_ovld_s,
  input  logic              acc_clear,
  input  logic              drain_req,
  input  logic              drain_ready,
  output logic              drain_valid,
  output logic [ACC_W-1:0]  drain_data,
  output logic              busy,
  output logic              drop_err
);

  pe_state_e                state_q, state_d;
  pe_mode_e                 mode_q;
  logic [1:0]               dir_q;
  logic signed [DATA_W-1:0] weight_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic                     drop_err_q;

  logic signed [DATA_W-1:0] h_src, h_fwd_d, mac_b;
  logic                     h_src_vld, h_fwd_vld_d;
  logic signed [ACC_W-1:0]  v_src, v_fwd_d, b_ext, mac_addend, mac_sum;
  logic                     v_src_vld, v_fwd_vld_d;
  logic                     ws_run, os_act, mac_fire, any_in_vld;

  logic signed [DATA_W-1:0] h_out_w_p1, h_out_e_p1;
  logic signed [ACC_W-1:0]  v_out_n_p1, v_out_s_p1;
  logic                     h_vld_w_p1, h_vld_e_p1, v_vld_n_p1, v_vld_s_p1;

  // ---- stage p0: source selection and mode decode ----
  assign h_src     = dir_q[DIR_H] ? h_in_e  : h_in_w;
  assign h_src_vld = dir_q[DIR_H] ? h_vld_e : h_vld_w;
  assign v_src     = dir_q[DIR_V] ? v_in_s  : v_in_n;
  assign v_src_vld = dir_q[DIR_V] ? v_vld_s : v_vld_n;

  assign ws_run     = (state_q == ST_RUN) && (mode_q == PE_WS);
  assign os_act     = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && (mode_q == PE_OS);
  assign mac_fire   = (state_q == ST_RUN) && (mode_q == PE_OS) && h_src_vld && v_src_vld;
  assign any_in_vld = h_vld_w | h_vld_e | v_vld_n | v_vld_s;

  assign b_ext = {{(ACC_W-DATA_W){SIGNED ? v_src[DATA_W-1] : 1'b0}}, v_src[DATA_W-1:0]};

  // One MAC serves both modes: WS adds the incoming psum, OS the local accumulator
  assign mac_b      = ws_run ? weight_q : v_src[DATA_W-1:0];
  assign mac_addend = ws_run ? v_src : (acc_clear ? '0 : acc_q);

  pe_mac_core #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .SIGNED (SIGNED)
  ) u_mac (
    .a      (h_src),
    .b      (mac_b),
    .addend (mac_addend),
    .sum    (mac_sum)
  );

  always_comb begin
    h_fwd_d     = h_src;
    h_fwd_vld_d = h_src_vld;
    v_fwd_d     = v_src;
    v_fwd_vld_d = v_src_vld;
    if (ws_run) begin
      v_fwd_d     = mac_sum;
      v_fwd_vld_d = h_src_vld & v_src_vld;
    end else if (os_act) begin
      v_fwd_d = b_ext;
    end
  end

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cfg_start) state_d = ST_RUN;
      ST_RUN: begin
        if (cfg_stop)                            state_d = ST_IDLE;
        else if (drain_req && (mode_q == PE_OS)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (drain_ready) state_d = ST_RUN;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    drain_valid = (state_q == ST_DRAIN);
    drain_data  = acc_q;
  end

  // ---- configuration, weight, accumulator and error state ----
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= PE_PASS;
      dir_q      <= '0;
      weight_q   <= '0;
      acc_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      if (cfg_valid && (state_q == ST_IDLE)) begin
        mode_q <= pe_mode_e'(cfg_mode);
        dir_q  <= cfg_dir;
      end
      if (stat_load && (state_q != ST_DRAIN))
        weight_q <= stat_data;
      if (state_q == ST_DRAIN) begin
        if (drain_ready) acc_q <= '0;
      end else if (mac_fire) begin
        acc_q <= mac_sum;
      end else if (acc_clear) begin
        acc_q <= '0;
      end
      if ((state_q == ST_DRAIN) && any_in_vld)
        drop_err_q <= 1'b1;
    end
  end

  assign drop_err = drop_err_q;

  // ---- stage p1: registered outputs, inactive side held at zero ----
  always_ff @(posedge clk) begin
    if (reset) begin
      h_out_w_p1 <= '0;
      h_out_e_p1 <= '0;
      v_out_n_p1 <= '0;
      v_out_s_p1 <= '0;
      h_vld_w_p1 <= 1'b0;
      h_vld_e_p1 <= 1'b0;
      v_vld_n_p1 <= 1'b0;
      v_vld_s_p1 <= 1'b0;
    end else begin
      h_out_w_p1 <= dir_q[DIR_H] ? h_fwd_d : '0;
      h_out_e_p1 <= dir_q[DIR_H] ? '0 : h_fwd_d;
      h_vld_w_p1 <= dir_q[DIR_H] & h_fwd_vld_d;
      h_vld_e_p1 <= ~dir_q[DIR_H] & h_fwd_vld_d;
      v_out_n_p1 <= dir_q[DIR_V] ? v_fwd_d : '0;
      v_out_s_p1 <= dir_q[DIR_V] ? '0 : v_fwd_d;
      v_vld_n_p1 <= dir_q[DIR_V] & v_fwd_vld_d;
      v_vld_s_p1 <= ~dir_q[DIR_V] & v_fwd_vld_d;
    end
  end

  assign h_out_w  = h_out_w_p1;
  assign h_out_e  = h_out_e_p1;
  assign v_out_n  = v_out_n_p1;
  assign v_out_s  = v_out_s_p1;
  assign h_ovld_w = h_vld_w_p1;
  assign h_ovld_e = h_vld_e_p1;
  assign v_ovld_n = v_vld_n_p1;
  assign v_ovld_s = v_vld_s_p1;

endmodule

// File: tb/tb_reconfig_pe.sv
// Scoreboard bench for reconfig_pe: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares whenever the DUT presents valid data.
module tb_reconfig_pe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main instance, ACC_W = 24
  logic        cfg_valid, cfg_start, cfg_stop, stat_load;
  logic [1:0]  cfg_mode, cfg_dir;
  logic [7:0]  stat_data, h_in_w, h_in_e;
  logic        h_vld_w, h_vld_e, v_vld_n, v_vld_s;
  logic [23:0] v_in_n, v_in_s;
  logic [7:0]  h_out_w, h_out_e;
  logic        h_ovld_w, h_ovld_e, v_ovld_n, v_ovld_s;
  logic [23:0] v_out_n, v_out_s, drain_data;
  logic        acc_clear, drain_req, drain_ready, drain_valid, busy, drop_err;

  // narrow-accumulator instance, ACC_W = 16
  logic        s_cfg_valid, s_cfg_start, s_drain_req, s_drain_ready;
  logic [1:0]  s_cfg_mode;
  logic [7:0]  s_h_in_w;
  logic        s_h_vld_w, s_v_vld_n;
  logic [15:0] s_v_in_n;
  logic [7:0]  s_h_out_w, s_h_out_e;
  logic        s_h_ovld_w, s_h_ovld_e, s_v_ovld_n, s_v_ovld_s;
  logic [15:0] s_v_out_n, s_v_out_s, s_drain_data;
  logic        s_drain_valid, s_busy, s_drop_err;

  reconfig_pe #(.DATA_W(8), .ACC_W(24), .SIGNED(1'b1)) dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_mode(cfg_mode), .cfg_dir(cfg_dir),
    .cfg_start(cfg_start), .cfg_stop(cfg_stop), .stat_load(stat_load), .stat_data(stat_data),
    .h_in_w(h_in_w), .h_vld_w(h_vld_w), .h_in_e(h_in_e), .h_vld_e(h_vld_e),
    .v_in_n(v_in_n), .v_vld_n(v_vld_n), .v_in_s(v_in_s), .v_vld_s(v_vld_s),
    .h_out_w(h_out_w), .h_ovld_w(h_ovld_w), .h_out_e(h_out_e), .h_ovld_e(h_ovld_e),
    .v_out_n(v_out_n), .v_ovld_n(v_ovld_n), .v_out_s(v_out_s), .v_ovld_s(v_ovld_s),
    .acc_clear(acc_clear), .drain_req(drain_req), .drain_ready(drain_ready),
    .drain_valid(drain_valid), .drain_data(drain_data), .busy(busy), .drop_err(drop_err)
  );

  reconfig_pe #(.DATA_W(8), .ACC_W(16), .SIGNED(1'b1)) dut16 (
    .clk(clk), .reset(reset), .cfg_valid(s_cfg_valid), .cfg_mode(s_cfg_mode), .cfg_dir(2'b00),
    .cfg_start(s_cfg_start), .cfg_stop(1'b0), .stat_load(1'b0), .stat_data(8'h00),
    .h_in_w(s_h_in_w), .h_vld_w(s_h_vld_w), .h_in_e(8'h00), .h_vld_e(1'b0),
    .v_in_n(s_v_in_n), .v_vld_n(s_v_vld_n), .v_in_s(16'h0000), .v_vld_s(1'b0),
    .h_out_w(s_h_out_w), .h_ovld_w(s_h_ovld_w), .h_out_e(s_h_out_e), .h_ovld_e(s_h_ovld_e),
    .v_out_n(s_v_out_n), .v_ovld_n(s_v_ovld_n), .v_out_s(s_v_out_s), .v_ovld_s(s_v_ovld_s),
    .acc_clear(1'b0), .drain_req(s_drain_req), .drain_ready(s_drain_ready),
    .drain_valid(s_drain_valid), .drain_data(s_drain_data), .busy(s_busy), .drop_err(s_drop_err)
  );

`ifdef PE_SAT_EN
  localparam logic [15:0] EXP16 = 16'd32767;
`else
  localparam logic [15:0] EXP16 = 16'd15109;
`endif

  typedef struct {
    bit          side;
    logic [23:0] data;
  } exp_t;

  exp_t        h_q[$];
  exp_t        v_q[$];
  logic [23:0] d_q[$];
  logic [15:0] d16_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [1:0]  cur_dir = 2'b00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: output valid with no expected entry at %0t", name, $time);
  endtask

  // ---- monitor ----
  always @(negedge clk) begin
    exp_t e;
    if (h_ovld_e || h_ovld_w) begin
      if (h_q.size() == 0) unexpected("h_out");
      else begin
        e = h_q.pop_front();
        chk("h_side", 32'(h_ovld_w), 32'(e.side));
        chk("h_data", 32'(h_ovld_w ? h_out_w : h_out_e), 32'(e.data));
        chk("h_idle_side", h_ovld_w ? 32'({h_ovld_e, h_out_e}) : 32'({h_ovld_w, h_out_w}), 0);
      end
    end
    if (v_ovld_n || v_ovld_s) begin
      if (v_q.size() == 0) unexpected("v_out");
      else begin
        e = v_q.pop_front();
        chk("v_side", 32'(v_ovld_n), 32'(e.side));
        chk("v_data", 32'(v_ovld_n ? v_out_n : v_out_s), 32'(e.data));
        chk("v_idle_side", v_ovld_n ? 32'({v_ovld_s, v_out_s}) : 32'({v_ovld_n, v_out_n}), 0);
      end
    end
    if (drain_valid) begin
      if (d_q.size() == 0) unexpected("drain");
      else begin
        chk("drain_data", 32'(drain_data), 32'(d_q[0]));
        if (drain_ready) void'(d_q.pop_front());
      end
    end
    if (s_drain_valid) begin
      if (d16_q.size() == 0) unexpected("drain16");
      else begin
        chk("drain16_data", 32'(s_drain_data), 32'(d16_q[0]));
        if (s_drain_ready) void'(d16_q.pop_front());
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_h(input bit side, input logic [23:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    h_q.push_back(e);
  endtask

  task automatic exp_v(input bit side, input logic [23:0] data);
    exp_t e;
    e.side = side;
    e.data = data;
    v_q.push_back(e);
  endtask

  task automatic drive(input logic [7:0] hd, input logic hv, input logic [23:0] vd, input logic vv);
    if (cur_dir[0]) begin h_in_e = hd; h_vld_e = hv; end
    else            begin h_in_w = hd; h_vld_w = hv; end
    if (cur_dir[1]) begin v_in_s = vd; v_vld_s = vv; end
    else            begin v_in_n = vd; v_vld_n = vv; end
    cyc();
    h_vld_w = 1'b0; h_vld_e = 1'b0; v_vld_n = 1'b0; v_vld_s = 1'b0;
  endtask

  task automatic configure(input logic [1:0] mode, input logic [1:0] dir);
    cfg_valid = 1'b1; cfg_mode = mode; cfg_dir = dir;
    cyc();
    cfg_valid = 1'b0;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    cur_dir = dir;
  endtask

  task automatic stop_run();
    cfg_stop = 1'b1;
    cyc();
    cfg_stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cfg_valid = 0; cfg_start = 0; cfg_stop = 0; stat_load = 0; cfg_mode = 0; cfg_dir = 0;
    stat_data = 0; h_in_w = 0; h_in_e = 0; h_vld_w = 0; h_vld_e = 0;
    v_in_n = 0; v_in_s = 0; v_vld_n = 0; v_vld_s = 0;
    acc_clear = 0; drain_req = 0; drain_ready = 0;
    s_cfg_valid = 0; s_cfg_start = 0; s_cfg_mode = 0; s_drain_req = 0; s_drain_ready = 0;
    s_h_in_w = 0; s_h_vld_w = 0; s_v_in_n = 0; s_v_vld_n = 0;
    cyc(3);
    reset = 1'b0;

    // reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drain_valid", 32'(drain_valid), 0);
    chk("rst_drop_err", 32'(drop_err), 0);
    chk("rst_drain_data", 32'(drain_data), 0);
    chk("rst_h_out", 32'({h_ovld_e, h_out_e, h_ovld_w, h_out_w}), 0);
    chk("rst_v_out", 32'({v_ovld_s, v_out_s}), 0);

    // PASS, W->E / N->S forwarding
    configure(2'b10, 2'b00);
    chk("run_busy", 32'(busy), 1);
    exp_h(1'b0, 24'h5A);
    exp_v(1'b0, 24'h123456);
    drive(8'h5A, 1'b1, 24'h123456, 1'b1);

    // WS: weight 3, -2*3 + 100 = 94
    stop_run();
    stat_load = 1'b1; stat_data = 8'd3;
    cyc();
    stat_load = 1'b0;
    configure(2'b00, 2'b00);
    exp_h(1'b0, 24'hFE); exp_v(1'b0, 24'd94);
    drive(8'hFE, 1'b1, 24'd100, 1'b1);
    // load concurrent with MAC uses the old weight: 4*3 + 1 = 13
    stat_load = 1'b1; stat_data = 8'd7;
    exp_h(1'b0, 24'h04); exp_v(1'b0, 24'd13);
    drive(8'd4, 1'b1, 24'd1, 1'b1);
    stat_load = 1'b0;
    exp_h(1'b0, 24'h02); exp_v(1'b0, 24'd14);
    drive(8'd2, 1'b1, 24'd0, 1'b1);
    // only h valid: no psum valid
    exp_h(1'b0, 24'h09);
    drive(8'd9, 1'b1, 24'd5, 1'b0);
    // -2*7 + 0 = -14
    exp_h(1'b0, 24'hFE); exp_v(1'b0, 24'hFFFFF2);
    drive(8'hFE, 1'b1, 24'd0, 1'b1);

    // OS, E->W / S->N, clear with concurrent MAC on the first pair
    stop_run();
    configure(2'b01, 2'b11);
    acc_clear = 1'b1;
    exp_h(1'b1, 24'h02); exp_v(1'b1, 24'h000003);
    drive(8'd2, 1'b1, 24'hABCD03, 1'b1);
    acc_clear = 1'b0;
    exp_h(1'b1, 24'h04); exp_v(1'b1, 24'h000005);
    drive(8'd4, 1'b1, 24'h000005, 1'b1);
    exp_h(1'b1, 24'hFF); exp_v(1'b1, 24'h000007);
    drive(8'hFF, 1'b1, 24'h000007, 1'b1);
    // v alone: sign-extended forward, no MAC
    exp_v(1'b1, 24'hFFFFF0);
    drive(8'd0, 1'b0, 24'h0012F0, 1'b1);

    // drain 19 with ready held low 3 cycles
    d_q.push_back(24'd19);
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    chk("drain_busy", 32'(busy), 1);
    cyc(3);
    drain_ready = 1'b1;
    cyc();
    drain_ready = 1'b0;
    chk("drain_done_valid", 32'(drain_valid), 0);
    // accumulator cleared by the accepted drain
    d_q.push_back(24'd0);
    drain_req = 1'b1; drain_ready = 1'b1;
    cyc();
    drain_req = 1'b0;
    cyc();
    drain_ready = 1'b0;

    // valid input during DRAIN: forwarded, drop_err sticky, acc and acc_clear untouched
    exp_h(1'b1, 24'h03); exp_v(1'b1, 24'h000003);
    drive(8'd3, 1'b1, 24'd3, 1'b1);
    d_q.push_back(24'd9);
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    acc_clear = 1'b1;
    exp_h(1'b1, 24'h05); exp_v(1'b1, 24'h000005);
    drive(8'd5, 1'b1, 24'd5, 1'b1);
    acc_clear = 1'b0;
    chk("drop_err_set", 32'(drop_err), 1);
    cyc(2);
    chk("drop_err_sticky", 32'(drop_err), 1);
    drain_ready = 1'b1;
    cyc();
    drain_ready = 1'b0;
    chk("drop_err_after_drain", 32'(drop_err), 1);

    // cfg_valid in RUN ignored: still OS, still E->W / S->N
    cfg_valid = 1'b1; cfg_mode = 2'b10; cfg_dir = 2'b00;
    cyc();
    cfg_valid = 1'b0;
    exp_h(1'b1, 24'h02); exp_v(1'b1, 24'h000002);
    drive(8'd2, 1'b1, 24'h5A5A02, 1'b1);
    d_q.push_back(24'd4);
    drain_req = 1'b1;
    cyc();
    drain_req = 1'b0;
    cyc();
    // reset mid-DRAIN
    reset = 1'b1;
    cyc();
    d_q.delete();
    reset = 1'b0;
    chk("mid_rst_drain_valid", 32'(drain_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_drop_err", 32'(drop_err), 0);
    chk("mid_rst_acc", 32'(drain_data), 0);
    // back to PASS W->E in IDLE
    cur_dir = 2'b00;
    exp_h(1'b0, 24'h33);
    drive(8'h33, 1'b1, 24'd0, 1'b0);

    // ACC_W = 16: 127*127 accumulated 5 times
    s_cfg_valid = 1'b1; s_cfg_mode = 2'b01;
    cyc();
    s_cfg_valid = 1'b0; s_cfg_start = 1'b1;
    cyc();
    s_cfg_start = 1'b0;
    s_h_in_w = 8'd127; s_v_in_n = 16'd127; s_h_vld_w = 1'b1; s_v_vld_n = 1'b1;
    cyc(5);
    s_h_vld_w = 1'b0; s_v_vld_n = 1'b0;
    d16_q.push_back(EXP16);
    s_drain_req = 1'b1;
    cyc();
    s_drain_req = 1'b0; s_drain_ready = 1'b1;
    cyc();
    s_drain_ready = 1'b0;

    cyc(3);
    chk("h_q_empty", 32'(h_q.size()), 0);
    chk("v_q_empty", 32'(v_q.size()), 0);
    chk("d_q_empty", 32'(d_q.size()), 0);
    chk("d16_q_empty", 32'(d16_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
